// File: rtl/pll_phase_stepper.sv
// ============================================================================
// pll_phase_stepper
//
// Purpose:
//   Initiator side of the PLL dynamic phase-shift interface. A step request
//   names an output channel, a direction and a step count. The block then
//   drives PSSEL/PSDIR, waits a setup time, and emits a train of correctly
//   timed PSPULSE pulses. It also keeps a per-channel phase position
//   (modulo PHASE_STEPS) so software can read back where each clock sits.
//
// Optional feature (macro PLL_PHASE_STEPPER_LOCK_WAIT_EN):
//   When the macro is defined, SETUP and GAP do not finish until their
//   counter has expired and a 2-flop synchronised pll_lock is high. A pulse
//   that has already started always completes its full width.
//   When the macro is undefined, pll_lock is ignored and timing is fixed.
//
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   req_valid  in   step request valid
//   req_ready  out  high only in IDLE; accept = req_valid & req_ready
//   req_sel    in   [2:0] target channel (must be < NCH)
//   req_dir    in   0 = advance (+1 per step), 1 = retard (-1 per step)
//   req_steps  in   [7:0] number of steps, 0..255
//   pll_lock   in   PLL LOCK (used only with the optional feature)
//   pssel      out  [2:0] to PLLA PSSEL
//   psdir      out  to PLLA PSDIR
//   pspulse    out  to PLLA PSPULSE
//   busy       out  high when not in IDLE
//   done       out  one-cycle pulse when a request completes
//   err        out  one-cycle pulse when a request is rejected
//   pos_sel    in   [2:0] channel to read back
//   pos        out  [7:0] current phase of channel pos_sel (combinational)
// ============================================================================
module pll_phase_stepper #(
    parameter int NCH         = 4,
    parameter int PHASE_STEPS = 80,
    parameter int SETUP_CYC   = 4,
    parameter int PULSE_CYC   = 4,
    parameter int GAP_CYC     = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_steps,
    input  logic       pll_lock,
    output logic [2:0] pssel,
    output logic       psdir,
    output logic       pspulse,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic [2:0] pos_sel,
    output logic [7:0] pos
);

    // Counter wide enough for the longest of the three timed phases.
    localparam int MAXC_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC   = (MAXC_A > GAP_CYC) ? MAXC_A : GAP_CYC;
    localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [3:0] NCH4    = 4'(NCH);
    localparam logic [8:0] PS9     = 9'(PHASE_STEPS);
    localparam logic [7:0] PS_LAST = 8'(PHASE_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_GAP   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Phase arithmetic (modulo PHASE_STEPS, computed 9 bits wide so a
    // PHASE_STEPS of 256 still wraps correctly).
    // ------------------------------------------------------------------
    function automatic logic [7:0] pos_adv(input logic [7:0] p);
        logic [8:0] n;
        n = {1'b0, p} + 9'd1;
        return (n == PS9) ? 8'd0 : n[7:0];
    endfunction

    function automatic logic [7:0] pos_ret(input logic [7:0] p);
        return (p == 8'd0) ? PS_LAST : (p - 8'd1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [7:0]       rem_q,     rem_d;
    logic [2:0]       pssel_q,   pssel_d;
    logic             psdir_q,   psdir_d;
    logic             pspulse_q, pspulse_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;
    // Sized for the largest legal NCH; entries >= NCH are never written.
    logic [7:0]       pos_q [8];
    logic [7:0]       pos_d [8];
    logic             pos_upd;
    logic             lock_ok;

    // ------------------------------------------------------------------
    // Lock qualification
    // ------------------------------------------------------------------
`ifdef PLL_PHASE_STEPPER_LOCK_WAIT_EN
    logic lock_s1_q, lock_s2_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            lock_s1_q <= pll_lock;
            lock_s2_q <= lock_s1_q;
        end
    end

    assign lock_ok = lock_s2_q;
`else
    logic unused_pll_lock;
    assign unused_pll_lock = pll_lock;
    assign lock_ok         = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        pssel_d = pssel_q;
        psdir_d = psdir_q;
        err_d   = 1'b0;
        pos_upd = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if ({1'b0, req_sel} >= NCH4) begin
                        // Rejected: stay idle and leave PSSEL/PSDIR alone.
                        err_d = 1'b1;
                    end else if (req_steps == 8'd0) begin
                        state_d = S_FIN;
                    end else begin
                        pssel_d = req_sel;
                        psdir_d = req_dir;
                        rem_d   = req_steps;
                        cnt_d   = '0;
                        state_d = S_SETUP;
                    end
                end
            end

            S_SETUP: begin
                // Counter saturates at its last value while waiting for lock.
                if (cnt_q == SETUP_LAST) begin
                    if (lock_ok) begin
                        cnt_d   = '0;
                        state_d = S_PULSE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_PULSE: begin
                // Position moves on the rising cycle of each pulse. The pulse
                // width never depends on lock.
                pos_upd = (cnt_q == '0);
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (lock_ok) begin
                        cnt_d   = '0;
                        rem_d   = rem_q - 8'd1;
                        state_d = (rem_q == 8'd1) ? S_FIN : S_PULSE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they are glitch-free
        // at the PLL pins.
        pspulse_d = (state_d == S_PULSE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FIN);
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pos_d[i] = pos_q[i];
        end
        if (pos_upd) begin
            pos_d[pssel_q] = psdir_q ? pos_ret(pos_q[pssel_q])
                                     : pos_adv(pos_q[pssel_q]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            pssel_q   <= '0;
            psdir_q   <= 1'b0;
            pspulse_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            pssel_q   <= pssel_d;
            psdir_q   <= psdir_d;
            pspulse_q <= pspulse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            for (int i = 0; i < 8; i++) begin
                pos_q[i] <= pos_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign req_ready = (state_q == S_IDLE);
    assign pssel     = pssel_q;
    assign psdir     = psdir_q;
    assign pspulse   = pspulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // Out-of-range channels read back as zero.
    always_comb begin
        pos = 8'd0;
        if ({1'b0, pos_sel} < NCH4) begin
            pos = pos_q[pos_sel];
        end
    end

endmodule

// File: tb/tb_pll_phase_stepper.sv
`timescale 1ns/1ps
module tb_pll_phase_stepper;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_sel;
    logic       req_dir;
    logic [7:0] req_steps;
    logic       pll_lock;
    logic [2:0] pssel;
    logic       psdir;
    logic       pspulse;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] pos_sel;
    logic [7:0] pos;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pll_phase_stepper dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_dir   (req_dir),
        .req_steps (req_steps),
        .pll_lock  (pll_lock),
        .pssel     (pssel),
        .psdir     (psdir),
        .pspulse   (pspulse),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pos_sel   (pos_sel),
        .pos       (pos)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one cycle; returns in cycle 1
    // (the cycle after the accept cycle).
    task automatic send(input logic [2:0] s, input logic d, input logic [7:0] n);
        req_valid = 1'b1;
        req_sel   = s;
        req_dir   = d;
        req_steps = n;
        pos_sel   = s;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic read_pos(input logic [2:0] ch, output logic [7:0] v);
        pos_sel = ch;
        #1;
        v = pos;
    endtask

    // Watch one request from cycle 1 until done (or budget expiry).
    // Cycle numbers are counted from the accept cycle (= cycle 0).
    task automatic observe(input logic [2:0] sel, input logic dir, input int budget,
                           output int first_rise, output int last_rise, output int rises,
                           output int highs, output int done_at, output int sel_bad,
                           output int pos_chg);
        logic       prev;
        logic [7:0] p0;
        first_rise = -1; last_rise = -1; rises = 0; highs = 0;
        done_at = -1; sel_bad = 0; pos_chg = -1;
        prev = 1'b0;
        p0 = pos;
        for (int k = 1; k <= budget; k++) begin
            if (pspulse && !prev) begin
                rises++;
                last_rise = k;
                if (first_rise < 0) first_rise = k;
            end
            if (pspulse) highs++;
            if (pos !== p0 && pos_chg < 0) pos_chg = k;
            if (busy && !done && (pssel !== sel || psdir !== dir)) sel_bad++;
            if (done) begin
                done_at = k;
                break;
            end
            prev = pspulse;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fr, lr, nr, nh, da, sb, pc, n;
        logic [7:0] v;

        resetn = 1'b0; req_valid = 1'b0; req_sel = '0; req_dir = 1'b0;
        req_steps = '0; pll_lock = 1'b1; pos_sel = '0;
        tick(); tick();

        // ---- reset state ----
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pspulse", pspulse, 0);
        check("rst_pssel", pssel, 0);
        check("rst_psdir", psdir, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        for (int c = 0; c < 4; c++) begin
            read_pos(3'(c), v);
            check("rst_pos", v, 0);
        end
        resetn = 1'b1;
        tick();

        // ---- ch2 advance 3 steps ----
        send(3'd2, 1'b0, 8'd3);
        check("t1_busy", busy, 1);
        check("t1_ready_low", req_ready, 0);
        observe(3'd2, 1'b0, 100, fr, lr, nr, nh, da, sb, pc);
        check("t1_first_rise", fr, 5);
        check("t1_last_rise", lr, 29);
        check("t1_rises", nr, 3);
        check("t1_high_cycles", nh, 12);
        check("t1_done_at", da, 41);
        check("t1_sel_stable", sb, 0);
        check("t1_pos_visible", pc, 6);
        tick();
        check("t1_done_one_cycle", done, 0);
        check("t1_ready_back", req_ready, 1);
        read_pos(3'd2, v);
        check("t1_pos2", v, 3);

        // ---- ch1 retard wrap, then advance ----
        send(3'd1, 1'b1, 8'd1);
        observe(3'd1, 1'b1, 100, fr, lr, nr, nh, da, sb, pc);
        check("t2_rises", nr, 1);
        check("t2_done_at", da, 17);
        check("t2_dir_stable", sb, 0);
        tick();
        read_pos(3'd1, v);
        check("t2_pos1_wrap", v, 79);
        send(3'd1, 1'b0, 8'd2);
        observe(3'd1, 1'b0, 100, fr, lr, nr, nh, da, sb, pc);
        check("t2b_rises", nr, 2);
        check("t2b_done_at", da, 29);
        tick();
        read_pos(3'd1, v);
        check("t2b_pos1", v, 1);

        // ---- ch0 to 78, then advance 5 across the wrap ----
        send(3'd0, 1'b1, 8'd2);
        observe(3'd0, 1'b1, 100, fr, lr, nr, nh, da, sb, pc);
        tick();
        read_pos(3'd0, v);
        check("t3_pos0_78", v, 78);
        send(3'd0, 1'b0, 8'd5);
        observe(3'd0, 1'b0, 200, fr, lr, nr, nh, da, sb, pc);
        check("t3_rises", nr, 5);
        // busy budget 1+4+5*12+1 counts from the accept cycle through done
        check("t3_busy_span", da + 1, 66);
        tick();
        read_pos(3'd0, v);
        check("t3_pos0", v, 3);

        // ---- zero steps ----
        send(3'd3, 1'b0, 8'd0);
        observe(3'd3, 1'b0, 10, fr, lr, nr, nh, da, sb, pc);
        check("t4_no_pulse", nr, 0);
        check("t4_done_at", da, 1);
        tick();
        check("t4_ready", req_ready, 1);

        // ---- illegal channel ----
        send(3'd5, 1'b1, 8'd3);
        check("t4_err", err, 1);
        check("t4_err_no_done", done, 0);
        check("t4_err_busy", busy, 0);
        check("t4_err_ready", req_ready, 1);
        check("t4_err_pssel", pssel, 0);
        check("t4_err_psdir", psdir, 0);
        tick();
        check("t4_err_one_cycle", err, 0);
        check("t4_err_no_done2", done, 0);
        read_pos(3'd0, v); check("t4_pos0", v, 3);
        read_pos(3'd1, v); check("t4_pos1", v, 1);
        read_pos(3'd2, v); check("t4_pos2", v, 3);
        read_pos(3'd5, v); check("t4_pos_oob", v, 0);

        // ---- busy ignore + async reset mid-pulse ----
        send(3'd3, 1'b0, 8'd10);
        req_valid = 1'b1; req_sel = 3'd1; req_dir = 1'b0; req_steps = 8'd1;
        tick();
        check("t5_ready_busy", req_ready, 0);
        tick();
        req_valid = 1'b0;
        n = 3;
        while (!pspulse && n < 20) begin
            tick();
            n++;
        end
        check("t5_pulse_at", n, 5);
        check("t5_pssel", pssel, 3);
        tick();
        read_pos(3'd3, v); check("t5_pos3", v, 1);
        read_pos(3'd1, v); check("t5_ignored_req", v, 1);
        check("t5_mid_pulse", pspulse, 1);
        #1 resetn = 1'b0;
        #1;
        check("t5_async_pspulse", pspulse, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_ready", req_ready, 1);
        for (int c = 0; c < 4; c++) begin
            read_pos(3'(c), v);
            check("t5_rst_pos", v, 0);
        end
        resetn = 1'b1;
        tick();
        check("t5_ready_after", req_ready, 1);
        nh = 0;
        for (int k = 0; k < 20; k++) begin
            if (pspulse || busy) nh++;
            tick();
        end
        check("t5_steps_discarded", nh, 0);

`ifdef PLL_PHASE_STEPPER_LOCK_WAIT_EN
        // ---- lock wait ----
        pll_lock = 1'b0;
        tick(); tick(); tick();
        send(3'd2, 1'b0, 8'd1);
        nh = 0;
        for (int k = 0; k < 20; k++) begin
            if (pspulse) nh++;
            tick();
        end
        check("t6_no_pulse_unlocked", nh, 0);
        check("t6_busy_unlocked", busy, 1);
        pll_lock = 1'b1;
        n = 0;
        while (!pspulse && n < 10) begin
            tick();
            n++;
        end
        check("t6_rise_after_lock", (n >= 2 && n <= 3), 1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("t6_done", done, 1);
        tick();
        read_pos(3'd2, v);
        check("t6_pos2", v, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
